// File: rtl/alu_link_pkg.sv
// -----------------------------------------------------------------------------
// alu_link_pkg
// Shared types and constants for the ALU result UART link.
//   tx_state_t          : transmitter FSM states
//   DATA_BITS           : payload bits per frame
//   IDLE_LEVEL          : idle / stop level of the serial line
//   FLAG_*_IDX          : bit positions of the ALU flags inside `flags`
//   calc_clks_per_bit() : clock cycles per UART bit (integer division)
//   pack_byte()         : {result, flags} payload packing
// -----------------------------------------------------------------------------
package alu_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int FLAG_Z_IDX = 0;
    localparam int FLAG_N_IDX = 1;
    localparam int FLAG_C_IDX = 2;
    localparam int FLAG_V_IDX = 3;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Result in the upper nibble, flags in the lower nibble so Z goes out first.
    function automatic logic [7:0] pack_byte(input logic [3:0] result,
                                             input logic [3:0] flags);
        return {result, flags};
    endfunction

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// -----------------------------------------------------------------------------
// alu_result_uart_tx_if
// Signal bundle between the ALU datapath and the result UART transmitter.
//   result  : ALU result Y (4 bits)
//   flags   : {V,C,N,Z}
//   start   : one-cycle forced-send request
//   uart_tx : serial line, idle high
//   busy    : high while a frame is on the line
//   done    : one-cycle pulse on the last stop-bit cycle
// master = ALU side (drives result/flags/start), slave = transmitter.
// -----------------------------------------------------------------------------
interface alu_result_uart_tx_if;

    logic [3:0] result;
    logic [3:0] flags;
    logic       start;
    logic       uart_tx;
    logic       busy;
    logic       done;

    modport master (
        output result, flags, start,
        input  uart_tx, busy, done
    );

    modport slave (
        input  result, flags, start,
        output uart_tx, busy, done
    );

endinterface

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Bit-period timer for the UART transmitter.
//   clk   : system clock, rising edge
//   rst   : synchronous active-low reset
//   en    : count enable; counter is held at 0 while low
//   tick  : high on the last cycle of each bit period
//   count : current position inside the bit period (0..CLKS_PER_BIT-1)
// -----------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 10,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(CLKS_PER_BIT - 1));

    // NOTE: reset is sampled on the clock edge (synchronous); state uses <= only.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tick  = en && w_last;
    assign count = r_count;

endmodule

// File: rtl/alu_result_uart_tx.sv
// -----------------------------------------------------------------------------
// alu_result_uart_tx
// Packs the ALU result and flags into one byte and sends it as 8N1 UART
// whenever the byte differs from the last one sent, or when `start` pulses.
//   clk           : system clock, rising edge
//   rst           : synchronous active-low reset
//   bus (slave)   : result, flags, start in; uart_tx, busy, done out
// Optional build macro ALU_TX_PARITY_EN: inserts an even-parity bit between
// the data bits and the stop bit (8E1, 11-bit frames).
// -----------------------------------------------------------------------------
module alu_result_uart_tx
    import alu_link_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_uart_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_t  r_state;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_last_sent;
    logic       r_sent_valid;
`ifdef ALU_TX_PARITY_EN
    logic       r_parity;
`endif

    logic [7:0]       w_pkt;
    logic             w_req;
    logic             w_tick;
    logic [CNT_W-1:0] w_cnt;

    assign w_pkt = pack_byte(bus.result, bus.flags);

    // Only looked at in IDLE; anything arriving while busy is picked up by the
    // comparison against last_sent once the line is free again.
    assign w_req = bus.start || !r_sent_valid || (w_pkt != r_last_sent);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .en    (r_state != IDLE),
        .tick  (w_tick),
        .count (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_tx         <= IDLE_LEVEL;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_last_sent  <= '0;
            r_sent_valid <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_shift      <= w_pkt;
                        r_last_sent  <= w_pkt;
                        r_sent_valid <= 1'b1;
`ifdef ALU_TX_PARITY_EN
                        r_parity     <= ^w_pkt;
`endif
                        r_bit_idx    <= '0;
                        r_tx         <= ~IDLE_LEVEL;
                        r_busy       <= 1'b1;
                        r_state      <= START;
                    end
                end

                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= DATA;
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef ALU_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= IDLE_LEVEL;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end
                end

`ifdef ALU_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_tx    <= IDLE_LEVEL;
                        r_state <= STOP;
                    end
                end
`endif

                STOP: begin
                    // done is registered, so it is raised one cycle early to
                    // land exactly on the final stop-bit cycle.
                    if (w_cnt == CNT_W'(CLKS_PER_BIT - 2)) begin
                        r_done <= 1'b1;
                    end
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.uart_tx = r_tx;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_alu_result_uart_tx
// Self-checking bench for alu_result_uart_tx with CLK_FREQ=1000, BAUD=100
// (10 clocks per bit). Outputs are sampled and inputs driven on the falling
// edge. Honours ALU_TX_PARITY_EN for frame length and parity bit checks.
// -----------------------------------------------------------------------------
module tb_alu_result_uart_tx;

    localparam int CPB = 10;
`ifdef ALU_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    typedef struct {
        int          latency;
        bit          timeout;
        int          busy_len;
        int          done_n;
        int          done_off;
        logic [10:0] bits;
    } frame_t;

    typedef struct {
        logic [3:0] result;
        logic [3:0] flags;
        logic       start;
        logic [7:0] exp_byte;
        logic       exp_par;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_result_uart_tx_if bus ();

    alu_result_uart_tx #(
        .CLK_FREQ (1000),
        .BAUD     (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for busy, then records the frame until busy drops.
    // Optional mid-frame stimulus: pkt changes at chg1_off/chg2_off and a
    // start pulse at start_off (frame-relative cycle offsets, -1 = unused).
    task automatic capture(input int chg1_off, input logic [7:0] chg1_val,
                           input int chg2_off, input logic [7:0] chg2_val,
                           input int start_off, output frame_t f);
        int off;
        f.latency  = 0;
        f.timeout  = 1'b0;
        f.busy_len = 0;
        f.done_n   = 0;
        f.done_off = -1;
        f.bits     = '1;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            f.latency++;
        end while (!bus.busy && f.latency < 50);
        if (!bus.busy) begin
            f.timeout = 1'b1;
            return;
        end
        off = 0;
        while (bus.busy && off < 200) begin
            if ((off % CPB) == CPB / 2 && (off / CPB) < 11) begin
                f.bits[off / CPB] = bus.uart_tx;
            end
            if (bus.done) begin
                f.done_n++;
                f.done_off = off;
            end
            if (off == chg1_off) {bus.result, bus.flags} = chg1_val;
            if (off == chg2_off) {bus.result, bus.flags} = chg2_val;
            bus.start = (off == start_off);
            @(negedge clk);
            off++;
        end
        bus.start  = 1'b0;
        f.busy_len = off;
        if (bus.busy) f.timeout = 1'b1;
    endtask

    task automatic check_frame(input string tag, input frame_t f,
                               input logic [7:0] exp_byte, input logic exp_par);
        check($sformatf("%s timeout", tag), {31'd0, f.timeout}, 32'd0);
        check($sformatf("%s latency", tag), f.latency, 1);
        check($sformatf("%s start_bit", tag), {31'd0, f.bits[0]}, 32'd0);
        check($sformatf("%s data", tag), {24'd0, f.bits[8:1]}, {24'd0, exp_byte});
`ifdef ALU_TX_PARITY_EN
        check($sformatf("%s parity", tag), {31'd0, f.bits[9]}, {31'd0, exp_par});
`endif
        check($sformatf("%s stop_bit", tag), {31'd0, f.bits[FRAME_BITS-1]}, 32'd1);
        check($sformatf("%s busy_len", tag), f.busy_len, FRAME_CYC);
        check($sformatf("%s done_count", tag), f.done_n, 1);
        check($sformatf("%s done_pos", tag), f.done_off, FRAME_CYC - 1);
    endtask

    // Watches the idle line for a number of cycles.
    task automatic quiet(input string tag, input int cycles);
        int busy_seen;
        int low_seen;
        int done_seen;
        busy_seen = 0;
        low_seen  = 0;
        done_seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.busy)     busy_seen++;
            if (!bus.uart_tx) low_seen++;
            if (bus.done)     done_seen++;
        end
        check($sformatf("%s busy_cycles", tag), busy_seen, 0);
        check($sformatf("%s line_low_cycles", tag), low_seen, 0);
        check($sformatf("%s done_pulses", tag), done_seen, 0);
    endtask

    vec_t   vecs[6];
    frame_t fr;
    int     wait_n;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // {result, flags, start, expected byte, expected even parity}
        vecs[0] = '{4'hA, 4'h4, 1'b0, 8'hA4, 1'b1};  // change while idle
        vecs[1] = '{4'hA, 4'h4, 1'b1, 8'hA4, 1'b1};  // forced resend
        vecs[2] = '{4'h3, 4'hC, 1'b1, 8'h3C, 1'b0};  // start + change: one frame
        vecs[3] = '{4'hF, 4'hF, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{4'h0, 4'h7, 1'b0, 8'h07, 1'b1};
        vecs[5] = '{4'h0, 4'h3, 1'b0, 8'h03, 1'b0};

        rst        = 1'b0;
        bus.result = 4'h0;
        bus.flags  = 4'h1;
        bus.start  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset uart_tx", {31'd0, bus.uart_tx}, 32'd1);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);

        // First frame right after reset release carries 8'h01
        rst = 1'b1;
        capture(-1, 8'h00, -1, 8'h00, -1, fr);
        check_frame("first", fr, 8'h01, 1'b1);

        // Unchanged inputs: line stays idle
        quiet("hold", 500);

        // Table-driven frames, each followed by a quiet window
        for (int i = 0; i < 6; i++) begin
            bus.result = vecs[i].result;
            bus.flags  = vecs[i].flags;
            bus.start  = vecs[i].start;
            capture(-1, 8'h00, -1, 8'h00, -1, fr);
            check_frame($sformatf("vec%0d", i), fr, vecs[i].exp_byte, vecs[i].exp_par);
            quiet($sformatf("vec%0d_after", i), 30);
        end

        // Mid-frame pkt changes: current frame unchanged, only the last value follows
        bus.start = 1'b1;
        capture(30, 8'h3C, 60, 8'h5F, -1, fr);
        check_frame("midchg_cur", fr, 8'h03, 1'b0);
        // Back-to-back frame; a start pulse during it must be dropped
        capture(-1, 8'h00, -1, 8'h00, 50, fr);
        check_frame("midchg_next", fr, 8'h5F, 1'b0);
        quiet("midchg_after", 40);

        // Reset pulse at cycle 45 of a frame
        bus.start = 1'b1;
        wait_n = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            wait_n++;
        end while (!bus.busy && wait_n < 50);
        check("rstmid launch", {31'd0, bus.busy}, 32'd1);
        repeat (45) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid uart_tx", {31'd0, bus.uart_tx}, 32'd1);
        check("rstmid busy", {31'd0, bus.busy}, 32'd0);
        check("rstmid done", {31'd0, bus.done}, 32'd0);
        rst = 1'b1;
        capture(-1, 8'h00, -1, 8'h00, -1, fr);
        check_frame("rstmid_recover", fr, 8'h5F, 1'b0);
        quiet("rstmid_after", 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
- Downstream stage of the ALU datapath. Packs the 4-bit ALU result and the Z/N/C/V flags into one byte and transmits it as 8N1 UART back to the ESP.
- Sends automatically whenever the packed byte differs from the last byte sent. A one-cycle `start` pulse forces a resend.
- Sits beside the seven-segment and PWM consumers in the top level, in the same `clk` domain as the ALU.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division), clock cycles per UART bit; must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset.
- result  input  4  ALU result Y.
- flags  input  4  {V,C,N,Z} as bits [3:0] = {V,C,N,Z}.
- start  input  1  one-cycle forced-send request.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line.
- done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-low.
- Reset values (`rst`=0 at a rising edge):
  - uart_tx=1, busy=0, done=0.
  - FSM=IDLE, bit and baud counters=0.
  - last_sent register=8'h00, sent_valid=0.
- Packed byte: pkt = {result[3:0], flags[3:0]}; transmitted LSB first (Z first).
- Send request, evaluated only in IDLE: req = start | ~sent_valid | (pkt != last_sent).
  - First cycle after reset always yields a send.
- Launch, on a cycle n in IDLE with req=1:
  - Latch pkt into the shift register and into last_sent; set sent_valid=1.
  - Go to START. From cycle n+1: uart_tx=0, busy=1.
- FSM:
  - IDLE → START on req.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA: shifts 8 bits, CLKS_PER_BIT cycles each, bit index 0..7.
  - DATA → STOP after bit 7 completes.
  - STOP drives uart_tx=1 for CLKS_PER_BIT cycles, then → IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles with busy=1.
- End of frame: done=1 for exactly one cycle, the final cycle of STOP. busy falls on the following cycle with the state back in IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is held at 0 in IDLE.
- Inputs while busy: changes to result/flags are ignored and `start` is dropped. After returning to IDLE, req is re-evaluated with the current pkt, so the latest value is always eventually sent.
- Back-to-back frames: if req=1 in the first IDLE cycle, the next START begins the following cycle. Minimum one idle-high cycle between frames.
- `start` and a changed pkt in the same IDLE cycle produce a single frame.
- Reset mid-frame: uart_tx returns to 1 on that edge, the frame is abandoned, and sent_valid=0, so a fresh frame follows once reset is released.
- No input synchronisers: result, flags and start are synchronous to clk.

Optional Feature:
- Macro: ALU_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted as state PARITY between DATA and STOP.
  - Frame is 11*CLKS_PER_BIT cycles (8E1).
  - done still pulses on the last STOP cycle.
- Undefined: PARITY state and logic are absent; 8N1, 10-bit frames.

Decomposition:
- Package alu_link_pkg:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - Constants: DATA_BITS=8, IDLE_LEVEL=1'b1, FLAG_Z_IDX=0, FLAG_N_IDX=1, FLAG_C_IDX=2, FLAG_V_IDX=3.
  - Function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
- Sub-module uart_baud_counter:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst, en; output tick, high on the last cycle of each bit.
  - Clears to 0 when en=0.

Test Plan (CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10):
- Release reset with result=4'h0, flags=4'h1 → frame starts the next cycle. Line samples at bit centres read 0, then bits of 8'h01 LSB-first, then 1. busy high for 100 cycles; done pulses once.
- Hold inputs constant after the first frame for 500 cycles → uart_tx stays 1, busy stays 0, no done.
- Change to result=4'hA, flags=4'h4 while idle → exactly one frame carrying 8'hA4. Pulse start afterwards → 8'hA4 resent.
- Change pkt to 8'h3C at cycle 30 of a frame, then to 8'h5F at cycle 60 → current frame completes unchanged. The next frame starts one cycle after done and carries 8'h5F only.
- Assert rst=0 for one cycle at cycle 45 of a frame → uart_tx=1 on that edge, busy=0. After release a new full frame of the current pkt is sent.
- With ALU_TX_PARITY_EN defined, send 8'h07 → parity bit 1, frame 110 cycles. Send 8'h03 → parity bit 0.
